ld_unit: RTL and testbench

Parametrised, sequential load unit for the Green datapath. Loads a DATA_W-wide result from data memory (direct or register-indirect address), or merges an ADDR_W-wide immediate into the low or high end of a selected source register. Generalises the combinational two-register load to NREG source registers and a req/ack memory handshake with timeout. It sits between instruction decode and the register-file write port and reports completion with a one-cycle valid pulse.

---
 rtl/ld_unit.sv | 152 +++++++++++++++
 tb/tb_ld_unit.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ld_unit.sv
// Sequential load unit: memory load (direct or register-indirect) or immediate
// merge into a selected source register, with req/ack handshake and timeout.
module ld_unit #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int NREG    = 4,
    parameter int TIMEOUT = 15,
    localparam int SEL_W  = (NREG > 2) ? $clog2(NREG) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [SEL_W-1:0]       src_sel,
    input  logic [ADDR_W-1:0]      imm,
    input  logic [NREG*DATA_W-1:0] regs_in,
    output logic                   mem_req,
    output logic [ADDR_W-1:0]      mem_addr,
    input  logic                   mem_ack,
    input  logic [DATA_W-1:0]      mem_rdata,
    output logic                   busy,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_err
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MEM,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        LD_MEM    = 2'b00,
        LD_IMM_LO = 2'b01,
        LD_IMM_HI = 2'b10,
        LD_IND    = 2'b11
    } ld_mode_e;

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [DATA_W-1:0] sel_val;
    logic [DATA_W-1:0] imm_lo;
    logic [DATA_W-1:0] imm_hi;
    logic              timeout_hit;
    ld_mode_e          mode_e;

    assign mode_e = ld_mode_e'(mode);

    // Out-of-range selects never match an index and therefore read as zero.
    always_comb begin
        sel_val = '0;
        for (int unsigned k = 0; k < NREG; k++) begin
            if (src_sel == SEL_W'(k)) begin
                sel_val = regs_in[k*DATA_W +: DATA_W];
            end
        end
    end

    if (DATA_W > ADDR_W) begin : g_merge
        assign imm_lo = {sel_val[DATA_W-1:ADDR_W], imm};
        assign imm_hi = {imm, sel_val[DATA_W-ADDR_W-1:0]};
    end else begin : g_merge_full
        assign imm_lo = imm;
        assign imm_hi = imm;
    end

    // cnt holds the number of completed ack-less MEM cycles before this one.
    always_comb begin
        timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            out_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        case (mode_e)
                            LD_IMM_LO: begin
                                out_data  <= imm_lo;
                                out_valid <= 1'b1;
                                out_err   <= 1'b0;
                                state     <= DONE;
                            end
                            LD_IMM_HI: begin
                                out_data  <= imm_hi;
                                out_valid <= 1'b1;
                                out_err   <= 1'b0;
                                state     <= DONE;
                            end
                            LD_MEM: begin
                                mem_addr <= imm;
                                mem_req  <= 1'b1;
                                cnt      <= '0;
                                state    <= MEM;
                            end
                            default: begin
                                mem_addr <= sel_val[ADDR_W-1:0];
                                mem_req  <= 1'b1;
                                cnt      <= '0;
                                state    <= MEM;
                            end
                        endcase
                    end
                end
                MEM: begin
                    // Ack takes priority over a timeout expiring in the same cycle.
                    if (mem_ack) begin
                        out_data  <= mem_rdata;
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_err   <= 1'b0;
                        state     <= DONE;
                    end else if (timeout_hit) begin
                        mem_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_err   <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    out_valid <= 1'b0;
                    out_err   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    mem_req   <= 1'b0;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    out_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ld_unit.sv
// Directed self-checking bench for ld_unit with default parameters
// (DATA_W=16, ADDR_W=8, NREG=4, TIMEOUT=15).
module tb_ld_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  mode;
    logic [1:0]  src_sel;
    logic [7:0]  imm;
    logic [63:0] regs_in;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_err;

    int tests = 0;
    int fails = 0;

    ld_unit #(
        .DATA_W (16),
        .ADDR_W (8),
        .NREG   (4),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode     (mode),
        .src_sel  (src_sel),
        .imm      (imm),
        .regs_in  (regs_in),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .busy     (busy),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_err  (out_err)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are driven and outputs sampled at the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Flags are {out_valid, out_err, busy, mem_req}.
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mode = 2'b00; src_sel = 2'd0; imm = 8'h00;
        regs_in = {16'h1277, 16'hABCD, 16'hABCD, 16'h0F0F};
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        step(); step();
        tests++;
        if ({out_valid, out_err, busy, mem_req} !== 4'b0000) begin
            fails++; $display("FAIL reset_flags got %b want 0000", {out_valid, out_err, busy, mem_req});
        end
        tests++;
        if ({out_data, mem_addr} !== 24'h000000) begin
            fails++; $display("FAIL reset_data got %h/%h want 0000/00", out_data, mem_addr);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_imm_lo();
        mode = 2'b01; src_sel = 2'd2; imm = 8'h12; start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({out_valid, out_err, busy, mem_req} !== 4'b1010 || out_data !== 16'hAB12) begin
            fails++; $display("FAIL imm_lo got flags %b data %h want 1010 AB12", {out_valid, out_err, busy, mem_req}, out_data);
        end
        step();
        tests++;
        if ({out_valid, busy, mem_req} !== 3'b000 || out_data !== 16'hAB12) begin
            fails++; $display("FAIL imm_lo_hold got flags %b data %h want 000 AB12", {out_valid, busy, mem_req}, out_data);
        end
    endtask

    task automatic test_imm_hi();
        mode = 2'b10; src_sel = 2'd1; imm = 8'h34; start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({out_valid, out_err, busy, mem_req} !== 4'b1010 || out_data !== 16'h34CD) begin
            fails++; $display("FAIL imm_hi got flags %b data %h want 1010 34CD", {out_valid, out_err, busy, mem_req}, out_data);
        end
        step();
    endtask

    // Back-to-back immediates: start held through DONE is ignored, accepted again in cycle 2.
    task automatic test_back_to_back();
        mode = 2'b10; src_sel = 2'd0; imm = 8'h99; start = 1'b1;
        step();
        imm = 8'h77;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h990F) begin
            fails++; $display("FAIL b2b_first got valid %b data %h want 1 990F", out_valid, out_data);
        end
        step();
        imm = 8'h11;
        tests++;
        if ({out_valid, busy} !== 2'b00 || out_data !== 16'h990F) begin
            fails++; $display("FAIL b2b_gap got flags %b data %h want 00 990F", {out_valid, busy}, out_data);
        end
        step();
        start = 1'b0;
        tests++;
        if (out_valid !== 1'b1 || out_data !== 16'h110F) begin
            fails++; $display("FAIL b2b_second got valid %b data %h want 1 110F", out_valid, out_data);
        end
        step();
    endtask

    task automatic test_mem();
        mode = 2'b00; src_sel = 2'd3; imm = 8'h40; start = 1'b1;
        step();
        // cycle 1: pulse start again while busy with a different request
        mode = 2'b01;
        tests++;
        if ({out_valid, busy, mem_req} !== 3'b011 || mem_addr !== 8'h40) begin
            fails++; $display("FAIL mem_c1 got flags %b addr %h want 011 40", {out_valid, busy, mem_req}, mem_addr);
        end
        step();
        start = 1'b0;
        tests++;
        if ({out_valid, mem_req} !== 2'b01 || mem_addr !== 8'h40) begin
            fails++; $display("FAIL mem_c2 got flags %b addr %h want 01 40", {out_valid, mem_req}, mem_addr);
        end
        step();
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        tests++;
        if ({out_valid, mem_req} !== 2'b01 || mem_addr !== 8'h40) begin
            fails++; $display("FAIL mem_c3 got flags %b addr %h want 01 40", {out_valid, mem_req}, mem_addr);
        end
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        tests++;
        if ({out_valid, out_err, busy, mem_req} !== 4'b1010 || out_data !== 16'hBEEF) begin
            fails++; $display("FAIL mem_done got flags %b data %h want 1010 BEEF", {out_valid, out_err, busy, mem_req}, out_data);
        end
        step();
        tests++;
        if ({out_valid, busy, mem_req} !== 3'b000) begin
            fails++; $display("FAIL mem_no_queue got flags %b want 000", {out_valid, busy, mem_req});
        end
    endtask

    task automatic test_ind();
        mode = 2'b11; src_sel = 2'd3; imm = 8'h40; start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if (mem_req !== 1'b1 || mem_addr !== 8'h77) begin
            fails++; $display("FAIL ind_addr got req %b addr %h want 1 77", mem_req, mem_addr);
        end
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        step();
        mem_ack = 1'b0;
        tests++;
        if ({out_valid, out_err, mem_req} !== 3'b100 || out_data !== 16'h5A5A) begin
            fails++; $display("FAIL ind_done got flags %b data %h want 100 5A5A", {out_valid, out_err, mem_req}, out_data);
        end
        step();
    endtask

    task automatic test_timeout();
        int bad_req;
        bad_req = 0;
        mode = 2'b00; imm = 8'h55; start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            if (mem_req !== 1'b1 || out_valid !== 1'b0) bad_req++;
            if (c < 15) step();
        end
        tests++;
        if (bad_req != 0) begin
            fails++; $display("FAIL timeout_req_window got %0d bad cycles want 0", bad_req);
        end
        step();
        tests++;
        if ({out_valid, out_err, mem_req} !== 3'b110 || out_data !== 16'h5A5A) begin
            fails++; $display("FAIL timeout_done got flags %b data %h want 110 5A5A", {out_valid, out_err, mem_req}, out_data);
        end
        step();
        tests++;
        if ({out_valid, out_err, busy} !== 3'b000) begin
            fails++; $display("FAIL timeout_idle got flags %b want 000", {out_valid, out_err, busy});
        end
        // Ack in the 15th request cycle must win over the expiring timeout.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 15; c++) step();
        mem_ack = 1'b1; mem_rdata = 16'hC0DE;
        tests++;
        if ({out_valid, mem_req} !== 2'b01) begin
            fails++; $display("FAIL ack_last_c15 got flags %b want 01", {out_valid, mem_req});
        end
        step();
        mem_ack = 1'b0;
        tests++;
        if ({out_valid, out_err, mem_req} !== 3'b100 || out_data !== 16'hC0DE) begin
            fails++; $display("FAIL ack_last_done got flags %b data %h want 100 C0DE", {out_valid, out_err, mem_req}, out_data);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int seen_valid;
        seen_valid = 0;
        mode = 2'b00; imm = 8'h40; start = 1'b1;
        step();
        start = 1'b0;
        step();
        tests++;
        if (mem_req !== 1'b1) begin
            fails++; $display("FAIL rst_mid_pre got req %b want 1", mem_req);
        end
        rst = 1'b1;
        #1;
        tests++;
        if ({mem_req, busy, out_valid} !== 3'b000 || out_data !== 16'h0000) begin
            fails++; $display("FAIL rst_mid_async got flags %b data %h want 000 0000", {mem_req, busy, out_valid}, out_data);
        end
        mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        step();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (out_valid !== 1'b0 || mem_req !== 1'b0) seen_valid++;
        end
        mem_ack = 1'b0;
        tests++;
        if (seen_valid != 0) begin
            fails++; $display("FAIL rst_mid_no_pulse got %0d bad cycles want 0", seen_valid);
        end
        mode = 2'b01; src_sel = 2'd0; imm = 8'hA5; start = 1'b1;
        step();
        start = 1'b0;
        tests++;
        if ({out_valid, out_err, mem_req} !== 3'b100 || out_data !== 16'h0FA5) begin
            fails++; $display("FAIL rst_mid_after got flags %b data %h want 100 0FA5", {out_valid, out_err, mem_req}, out_data);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_imm_lo();
        test_imm_hi();
        test_back_to_back();
        test_mem();
        test_ind();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
